// File: rtl/fifo_level.sv
// fifo_level: single-clock show-ahead FIFO with an occupancy count and registered
// empty/full/almost_empty/almost_full flags. All D entries are usable.
// Optional feature: define FIFO_ERR_EN to get sticky overflow/underflow flags
// cleared by err_clr. Without it both flags read 0 and err_clr is ignored.
module fifo_level #(
   parameter int B         = 8,
   parameter int W         = 4,
   parameter int AF_THRESH = 12,
   parameter int AE_THRESH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rd,
   input  logic         wr,
   input  logic [B-1:0] w_data,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic [W:0]   count,
   output logic         overflow,
   output logic         underflow,
   input  logic         err_clr
);

   localparam int         D      = 1 << W;
   localparam logic [W:0] D_CNT  = D[W:0];
   localparam logic [W:0] AF_CNT = AF_THRESH[W:0];
   localparam logic [W:0] AE_CNT = AE_THRESH[W:0];

   logic [B-1:0] mem [D];
   logic [W-1:0] w_ptr;
   logic [W-1:0] r_ptr;
   logic         rd_acc;
   logic         wr_acc;
   logic [W:0]   count_next;

   // Acceptance uses registered flags only; a full FIFO takes a write when the
   // same cycle's read frees the head slot.
   always_comb begin
      rd_acc     = rd & ~empty;
      wr_acc     = wr & (~full | rd_acc);
      count_next = count + {{W{1'b0}}, wr_acc} - {{W{1'b0}}, rd_acc};
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_acc && !reset) begin
         mem[w_ptr] <= w_data;
      end
   end

   // Pointers, count and flags, all derived from count_next.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_ptr        <= '0;
         r_ptr        <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
      end else begin
         if (wr_acc) w_ptr <= w_ptr + 1'b1;
         if (rd_acc) r_ptr <= r_ptr + 1'b1;
         count        <= count_next;
         empty        <= (count_next == '0);
         full         <= (count_next == D_CNT);
         almost_empty <= (count_next <= AE_CNT);
         almost_full  <= (count_next >= AF_CNT);
      end
   end

   // Show-ahead head word straight from the registered read pointer.
   always_comb begin
      r_data = mem[r_ptr];
   end

`ifdef FIFO_ERR_EN
   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr && !wr_acc)  overflow <= 1'b1;
         else if (err_clr)   overflow <= 1'b0;
         if (rd && !rd_acc)  underflow <= 1'b1;
         else if (err_clr)   underflow <= 1'b0;
      end
   end
`else
   logic unused_err_clr;

   // Error reporting compiled out: constant flags, err_clr has no effect.
   always_comb begin
      overflow       = 1'b0;
      underflow      = 1'b0;
      unused_err_clr = err_clr;
   end
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level (B=8, W=4, AF=12, AE=2). Works with or without
// FIFO_ERR_EN; expected error flags follow the same macro.
module tb_fifo_level;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rd = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] w_data = '0;
   logic       err_clr = 1'b0;
   logic [7:0] r_data;
   logic       empty, full, almost_empty, almost_full, overflow, underflow;
   logic [4:0] count;

   int checks = 0;
   int failures = 0;

`ifdef FIFO_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   fifo_level #(.B(8), .W(4), .AF_THRESH(12), .AE_THRESH(2)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data),
      .r_data(r_data), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
      .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with the given inputs; outputs are stable 1 time unit after the edge.
   task automatic cyc(input logic r, input logic w, input logic [7:0] d, input logic c = 1'b0);
      rd = r; wr = w; w_data = d; err_clr = c;
      @(posedge clk);
      #1;
      rd = 1'b0; wr = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      #1;
      // reset state
      reset = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ae", almost_empty, 1);
      check("rst_af", almost_full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_unf", underflow, 0);

      // 1: fill with 0x01..0x10, then drain in order
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, 1'b1, 8'(i));
         check("t1_count", count, i);
         check("t1_af", almost_full, (i >= 12));
         check("t1_full", full, (i == 16));
         check("t1_empty", empty, 0);
         check("t1_head", r_data, 8'h01);
      end
      for (int i = 1; i <= 16; i++) begin
         check("t1_rdata", r_data, i);
         cyc(1'b1, 1'b0, 8'h00);
         check("t1_rcount", count, 16 - i);
      end
      check("t1_empty_end", empty, 1);
      check("t1_ae_end", almost_empty, 1);

      // 2: overflow attempt on a full FIFO
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h20 + i));
      cyc(1'b0, 1'b1, 8'hAA);
      check("t2_count", count, 16);
      check("t2_full", full, 1);
      check("t2_ovf", overflow, ERR);
      check("t2_unf", underflow, 0);
      for (int i = 0; i < 16; i++) begin
         check("t2_rdata", r_data, 8'h20 + i);
         cyc(1'b1, 1'b0, 8'h00);
      end
      check("t2_empty", empty, 1);
      check("t2_ovf_held", overflow, ERR);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      check("t2_ovf_clr", overflow, 0);

      // 3: simultaneous rd&wr while full
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i));
      cyc(1'b1, 1'b1, 8'h55);
      check("t3_count", count, 16);
      check("t3_full", full, 1);
      check("t3_head", r_data, 8'h41);
      check("t3_ovf", overflow, 0);
      for (int i = 1; i < 16; i++) begin
         check("t3_rdata", r_data, 8'h40 + i);
         cyc(1'b1, 1'b0, 8'h00);
      end
      check("t3_tail", r_data, 8'h55);
      check("t3_count1", count, 1);
      cyc(1'b1, 1'b0, 8'h00);
      check("t3_empty", empty, 1);

      // 4: rd&wr while empty, then error-clear behaviour
      cyc(1'b1, 1'b1, 8'h33);
      check("t4_count", count, 1);
      check("t4_rdata", r_data, 8'h33);
      check("t4_empty", empty, 0);
      check("t4_unf", underflow, ERR);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      check("t4_unf_clr", underflow, 0);
      check("t4_count0", count, 0);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      check("t4_set_wins", underflow, ERR);
      check("t4_rd_empty_cnt", count, 0);
      check("t4_rd_empty_e", empty, 1);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      check("t4_unf_clr2", underflow, 0);

      // 5: almost_empty threshold walk 0->3->2
      check("t5_ae0", almost_empty, 1);
      cyc(1'b0, 1'b1, 8'hA1);
      check("t5_ae1", almost_empty, 1);
      cyc(1'b0, 1'b1, 8'hA2);
      check("t5_ae2", almost_empty, 1);
      cyc(1'b0, 1'b1, 8'hA3);
      check("t5_ae3", almost_empty, 0);
      cyc(1'b1, 1'b0, 8'h00);
      check("t5_ae2b", almost_empty, 1);
      check("t5_count", count, 2);

      // 6: reset with count=7 and wr=1, then pointer wrap
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'hB0 + i));
      check("t6_count7", count, 7);
      reset = 1'b1;
      cyc(1'b0, 1'b1, 8'hEE);
      reset = 1'b0;
      check("t6_rst_count", count, 0);
      check("t6_rst_empty", empty, 1);
      check("t6_rst_ae", almost_empty, 1);
      for (int k = 0; k < 40; k++) begin
         cyc(1'b0, 1'b1, 8'(8'h80 + k));
         check("t6_wrap_data", r_data, 8'h80 + k);
         cyc(1'b1, 1'b0, 8'h00);
      end
      check("t6_wrap_count", count, 0);
      check("t6_wrap_empty", empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
